arb_grant_mux: RTL and testbench

ARB_GRANT_MUX -- requirements
Module: arb_grant_mux

---
 rtl/arb_grant_mux_pkg.sv | 18 +
 rtl/arb_skid_buf2.sv | 79 +++++++
 rtl/arb_grant_mux.sv | 110 +++++++++++
 tb/tb_arb_grant_mux.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_grant_mux_pkg.sv
// Shared arbiter definitions: default source count / payload width and the
// helpers that size the id field and a buffered payload entry.
package arb_grant_mux_pkg;

    localparam int ARB_REQ_NUM_DEF = 8;
    localparam int ARB_DATA_WD_DEF = 32;

    // Width of a source index; a single source still needs a 1-bit id port.
    function automatic int arb_id_wd(input int req_num);
        return (req_num > 1) ? $clog2(req_num) : 1;
    endfunction

    // One buffered entry is {id, payload}.
    function automatic int arb_entry_wd(input int data_wd, input int id_wd);
        return data_wd + id_wd;
    endfunction

endpackage

// File: rtl/arb_skid_buf2.sv
// Two-entry in-order buffer. Slot 0 is always the head; slot 1 holds the
// second entry. Vacated slots are cleared so an empty buffer presents zeros.
module arb_skid_buf2
    import arb_grant_mux_pkg::*;
#(
    parameter int DATA_WD = ARB_DATA_WD_DEF,
    parameter int ID_WD   = arb_id_wd(ARB_REQ_NUM_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [DATA_WD-1:0] data_i,
    input  logic [ID_WD-1:0]   id_i,
    input  logic               pop_i,
    output logic [DATA_WD-1:0] head_data_o,
    output logic [ID_WD-1:0]   head_id_o,
    output logic [1:0]         count_o
);

    localparam int ENTRY_WD = arb_entry_wd(DATA_WD, ID_WD);

    logic [ENTRY_WD-1:0] slot0_q, slot0_d;
    logic [ENTRY_WD-1:0] slot1_q, slot1_d;
    logic [1:0]          count_q, count_d;
    logic [ENTRY_WD-1:0] entry_in;
    logic                pop_eff;
    logic                push_eff;

    assign entry_in = {id_i, data_i};
    // Ignore pops from empty and pushes into a full buffer that is not draining.
    assign pop_eff  = pop_i & (count_q != 2'd0);
    assign push_eff = push_i & ((count_q != 2'd2) | pop_eff);

    // Next-state: shift on pop, append at the first free slot on push.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({push_eff, pop_eff})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = entry_in;
                else                 slot1_d = entry_in;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                slot1_d = '0;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = entry_in;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = entry_in;
                end
            end
            default: ;
        endcase
    end

    // Buffer state; asynchronous reset discards everything held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_data_o = slot0_q[DATA_WD-1:0];
    assign head_id_o   = slot0_q[ENTRY_WD-1:DATA_WD];
    assign count_o     = count_q;

endmodule

// File: rtl/arb_grant_mux.sv
// Grant-driven payload mux between N sources and one downstream port.
// Requests go to an external arbiter only while the output buffer has room;
// the one-hot grant that comes back selects the payload to buffer.
module arb_grant_mux
    import arb_grant_mux_pkg::*;
#(
    parameter int  REQ_NUM = ARB_REQ_NUM_DEF,
    parameter int  DATA_WD = ARB_DATA_WD_DEF,
    localparam int ID_WD   = arb_id_wd(REQ_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQ_NUM-1:0]         s_valid,
    input  logic [REQ_NUM*DATA_WD-1:0] s_data,
    output logic [REQ_NUM-1:0]         s_ready,
    output logic [REQ_NUM-1:0]         arb_reqs,
    input  logic [REQ_NUM-1:0]         arb_grants,
    output logic                       m_valid,
    output logic [DATA_WD-1:0]         m_data,
    output logic [ID_WD-1:0]           m_id,
    input  logic                       m_ready,
    output logic                       grant_err,
    output logic [15:0]                beat_cnt
);

    logic [1:0]         count;
    logic               can_accept;
    logic               grant_multi;
    logic               grant_invalid;
    logic               grant_none;
    logic               grant_bad;
    logic               push;
    logic               pop;
    logic [DATA_WD-1:0] push_data;
    logic [ID_WD-1:0]   push_id;
    logic [DATA_WD-1:0] data_terms [REQ_NUM];
    logic [ID_WD-1:0]   id_terms   [REQ_NUM];
    logic               grant_err_q, grant_err_d;
    logic [15:0]        beat_cnt_q, beat_cnt_d;

    // Only registered occupancy gates requests, so m_ready never reaches s_ready.
    assign can_accept = (count < 2'd2);
    assign arb_reqs   = can_accept ? s_valid : '0;

    // Grant sanity: more than one bit, a bit on an idle source, or nothing at all.
    assign grant_multi   = |(arb_grants & (arb_grants - REQ_NUM'(1)));
    assign grant_invalid = |(arb_grants & ~s_valid);
    assign grant_none    = ~|arb_grants & |arb_reqs;
    assign grant_bad     = can_accept & (grant_multi | grant_invalid | grant_none);

    // A bad grant blocks the whole cycle so no source sees an accept.
    assign s_ready = (can_accept & ~grant_bad) ? (arb_grants & s_valid) : '0;
    assign push    = |s_ready;
    assign pop     = m_valid & m_ready;

    // AND-OR select: s_ready is one-hot or zero, so masked terms just OR together.
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_sel
        assign data_terms[gi] = {DATA_WD{s_ready[gi]}} & s_data[gi*DATA_WD +: DATA_WD];
        assign id_terms[gi]   = s_ready[gi] ? ID_WD'(gi) : '0;
    end

    // OR-reduce the masked payload and id terms.
    always_comb begin
        push_data = '0;
        push_id   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            push_data = push_data | data_terms[i];
            push_id   = push_id | id_terms[i];
        end
    end

    arb_skid_buf2 #(
        .DATA_WD (DATA_WD),
        .ID_WD   (ID_WD)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .data_i      (push_data),
        .id_i        (push_id),
        .pop_i       (pop),
        .head_data_o (m_data),
        .head_id_o   (m_id),
        .count_o     (count)
    );

    assign m_valid = (count != 2'd0);

    // Sticky error flag and saturating beat counter next-state.
    always_comb begin
        grant_err_d = grant_err_q | grant_bad;
        beat_cnt_d  = beat_cnt_q;
        if (pop && (beat_cnt_q != 16'hFFFF)) beat_cnt_d = beat_cnt_q + 16'd1;
    end

    // Status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_err_q <= 1'b0;
            beat_cnt_q  <= 16'd0;
        end else begin
            grant_err_q <= grant_err_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign grant_err = grant_err_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Directed bench for arb_grant_mux with a scoreboard of expected entries and
// a small weighted round-robin arbiter (weights 1..8) as the grant source.
module tb_arb_grant_mux;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  id;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   s_valid;
    logic [255:0] s_data;
    logic [7:0]   s_ready;
    logic [7:0]   arb_reqs;
    logic [7:0]   arb_grants;
    logic         m_valid;
    logic [31:0]  m_data;
    logic [2:0]   m_id;
    logic         m_ready;
    logic         grant_err;
    logic [15:0]  beat_cnt;

    logic         auto_arb;
    logic [7:0]   man_grant;
    logic [7:0]   wrr_grant;
    logic         arb_clr;
    int           wptr;
    int           wcred;

    ent_t         sb[$];
    logic [15:0]  exp_beats;
    logic         exp_err;
    int           n_tests;
    int           n_fail;
    logic         did_pop;
    logic [2:0]   pop_id;
    logic         last_mvalid;

    always #5 clk = ~clk;

    arb_grant_mux #(.REQ_NUM(8), .DATA_WD(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .arb_reqs   (arb_reqs),
        .arb_grants (arb_grants),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_id       (m_id),
        .m_ready    (m_ready),
        .grant_err  (grant_err),
        .beat_cnt   (beat_cnt)
    );

    assign arb_grants = auto_arb ? wrr_grant : man_grant;

    // Weighted arbiter model: stay on source p for p+1 grants, then move on.
    always_comb begin
        logic found;
        int   idx;
        wrr_grant = 8'h00;
        found     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = (wptr + k) % 8;
            if (!found && arb_reqs[idx]) begin
                wrr_grant[idx] = 1'b1;
                found          = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        int cur;
        int ncred;
        if (arb_clr) begin
            wptr  <= 0;
            wcred <= 0;
        end else if (s_ready != 8'h00) begin
            cur = 0;
            for (int k = 0; k < 8; k++) if (s_ready[k]) cur = k;
            ncred = (cur == wptr) ? wcred + 1 : 1;
            if (ncred >= cur + 1) begin
                wptr  <= (cur + 1) % 8;
                wcred <= 0;
            end else begin
                wptr  <= cur;
                wcred <= ncred;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) s_data[i*32 +: 32] = $urandom;
    endtask

    // One clock: check combinational outputs and head, advance the model, check status.
    task automatic cyc();
        logic       can;
        logic       bad;
        logic [7:0] g;
        logic [7:0] ereq;
        logic [7:0] erdy;
        ent_t       e;
        #1;
        can  = (sb.size() < 2);
        ereq = can ? s_valid : 8'h00;
        g    = arb_grants;
        bad  = can && (((g & (g - 8'd1)) != 8'h00) || ((g & ~s_valid) != 8'h00) ||
                       (g == 8'h00 && ereq != 8'h00));
        erdy = (can && !bad) ? (g & s_valid) : 8'h00;
        check("arb_reqs", 64'(arb_reqs), 64'(ereq));
        check("s_ready", 64'(s_ready), 64'(erdy));
        check("m_valid", 64'(m_valid), 64'(sb.size() != 0));
        last_mvalid = m_valid;
        did_pop = 1'b0;
        if (sb.size() != 0) begin
            check("m_data", 64'(m_data), 64'(sb[0].d));
            check("m_id", 64'(m_id), 64'(sb[0].id));
            did_pop = m_ready;
            pop_id  = sb[0].id;
        end
        e.d  = 32'h0;
        e.id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (erdy[i]) begin
                e.d  = s_data[i*32 +: 32];
                e.id = 3'(i);
            end
        end
        @(posedge clk);
        if (did_pop) begin
            void'(sb.pop_front());
            if (exp_beats != 16'hFFFF) exp_beats = exp_beats + 16'd1;
        end
        if (erdy != 8'h00) sb.push_back(e);
        if (bad) exp_err = 1'b1;
        @(negedge clk);
        check("beat_cnt", 64'(beat_cnt), 64'(exp_beats));
        check("grant_err", 64'(grant_err), 64'(exp_err));
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_beats = 16'd0;
        exp_err   = 1'b0;
        check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
        check({tag, "_m_data"}, 64'(m_data), 64'(0));
        check({tag, "_m_id"}, 64'(m_id), 64'(0));
        check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(0));
        check({tag, "_grant_err"}, 64'(grant_err), 64'(0));
        check({tag, "_arb_reqs"}, 64'(arb_reqs), 64'(s_valid));
        @(negedge clk);
        s_valid   = 8'h00;
        man_grant = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int id_hist[8];
        int pops_seen;
        int bubbles;

        n_tests   = 0;
        n_fail    = 0;
        exp_beats = 16'd0;
        exp_err   = 1'b0;
        rst_n     = 1'b0;
        s_valid   = 8'h05;
        s_data    = '0;
        man_grant = 8'h00;
        auto_arb  = 1'b0;
        arb_clr   = 1'b1;
        m_ready   = 1'b0;

        // Reset state: arb_reqs follows s_valid, nothing granted, all else zero.
        #3;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_m_id", 64'(m_id), 64'(0));
        check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
        check("rst_grant_err", 64'(grant_err), 64'(0));
        check("rst_arb_reqs", 64'(arb_reqs), 64'(8'h05));
        check("rst_s_ready", 64'(s_ready), 64'(0));
        @(negedge clk);
        s_valid = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        arb_clr = 1'b0;

        // Single source 2 with a matching grant.
        s_valid = 8'h04;
        s_data[2*32 +: 32] = 32'hA5A5_0002;
        man_grant = 8'h04;
        m_ready = 1'b1;
        cyc();
        s_valid = 8'h00;
        man_grant = 8'h00;
        s_data[2*32 +: 32] = 32'h0;
        check("single_m_valid", 64'(m_valid), 64'(1));
        check("single_m_data", 64'(m_data), 64'(32'hA5A5_0002));
        check("single_m_id", 64'(m_id), 64'(2));
        cyc();
        check("single_beat_cnt", 64'(beat_cnt), 64'(1));

        // Backpressure: two entries accepted, then requests drop; drain in order.
        auto_arb = 1'b1;
        s_valid  = 8'hFF;
        m_ready  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            cyc();
        end
        check("bp_sb_full", 64'(sb.size()), 64'(2));
        check("bp_arb_reqs_zero", 64'(arb_reqs), 64'(0));
        s_valid = 8'h00;
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) cyc();
        check("bp_drained", 64'(m_valid), 64'(0));

        // Full throughput with the weighted arbiter from a fresh round.
        arb_clr = 1'b1;
        cyc();
        arb_clr   = 1'b0;
        s_valid   = 8'hFF;
        pops_seen = 0;
        bubbles   = 0;
        for (int i = 0; i < 8; i++) id_hist[i] = 0;
        for (int c = 0; c < 100; c++) begin
            rand_data();
            cyc();
            if (c > 0 && !last_mvalid) bubbles++;
            if (did_pop) begin
                if (pops_seen < 36) id_hist[pop_id]++;
                pops_seen++;
            end
        end
        s_valid = 8'h00;
        cyc();
        check("tp_no_bubbles", 64'(bubbles), 64'(0));
        check("tp_beat_cnt", 64'(beat_cnt), 64'(16'd103));
        for (int i = 0; i < 8; i++) check($sformatf("wrr_weight_id%0d", i), 64'(id_hist[i]), 64'(i + 1));

        // Multi-hot grant: error set, nothing buffered; flag stays through legal traffic.
        auto_arb  = 1'b0;
        s_valid   = 8'hFF;
        man_grant = 8'h03;
        cyc();
        check("illegal_err", 64'(grant_err), 64'(1));
        check("illegal_no_push", 64'(m_valid), 64'(0));
        man_grant = 8'h10;
        rand_data();
        cyc();
        cyc();
        s_valid   = 8'h00;
        man_grant = 8'h00;
        cyc();
        cyc();
        check("illegal_sticky", 64'(grant_err), 64'(1));

        // Reset with the buffer full: entries discarded, nothing emitted afterwards.
        auto_arb = 1'b1;
        s_valid  = 8'hFF;
        m_ready  = 1'b0;
        cyc();
        cyc();
        check("midrst_full", 64'(m_valid), 64'(1));
        m_ready = 1'b1;
        do_reset("midrst");
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("midrst_no_stale", 64'(m_valid), 64'(0));
        end

        // Grant to a source whose valid is low.
        auto_arb  = 1'b0;
        s_valid   = 8'h01;
        man_grant = 8'h02;
        cyc();
        check("invalid_src_err", 64'(grant_err), 64'(1));
        do_reset("rst2");

        // Requests pending but no grant returned.
        s_valid   = 8'h01;
        man_grant = 8'h00;
        cyc();
        check("zero_grant_err", 64'(grant_err), 64'(1));
        s_valid = 8'h00;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
